// File: rtl/skin_tone_detect_if.sv
// Pixel stream bus from the Bayer-to-RGB stage into skin_tone_detect.
// The source drives it through master; the detector reads it through slave.
interface skin_tone_detect_if;
    logic [11:0] red;
    logic [11:0] green;
    logic [11:0] blue;
    logic        dval;
    logic        fval;

    modport master (output red, green, blue, dval, fval);
    modport slave  (input  red, green, blue, dval, fval);
endinterface

// File: rtl/skin_tone_detect.sv
// RGB to Cb/Cr skin classifier with a 3-stage pipeline.
// Also accumulates a per-frame skin bounding box and pixel count.
module skin_tone_detect #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int CB_MIN = 77,
    parameter int CB_MAX = 127,
    parameter int CR_MIN = 133,
    parameter int CR_MAX = 173
) (
    input  logic        iCLK,
    input  logic        iRST,
    skin_tone_detect_if.slave pix,
    output logic        oSKIN,
    output logic        oDVAL,
    output logic [10:0] oX,
    output logic [10:0] oY,
    output logic [10:0] oBOX_XMIN,
    output logic [10:0] oBOX_XMAX,
    output logic [10:0] oBOX_YMIN,
    output logic [10:0] oBOX_YMAX,
    output logic [19:0] oSKIN_CNT,
    output logic        oBOX_FOUND,
    output logic        oBOX_VALID
);
    localparam logic [10:0] XLast = 11'(IMG_W - 1);
    localparam logic [10:0] YLast = 11'(IMG_H - 1);
    localparam logic [7:0]  CbLo  = 8'(CB_MIN);
    localparam logic [7:0]  CbHi  = 8'(CB_MAX);
    localparam logic [7:0]  CrLo  = 8'(CR_MIN);
    localparam logic [7:0]  CrHi  = 8'(CR_MAX);
    localparam logic [10:0] MinInit = 11'h7FF;
    localparam logic [19:0] CntMax  = 20'hFFFFF;

    function automatic logic signed [17:0] mul(
        input logic signed [17:0] k,
        input logic [7:0]         v
    );
        return k * $signed({10'd0, v});
    endfunction

    function automatic logic [7:0] clamp8(input logic signed [17:0] v);
        if (v < 18'sd0)        return 8'd0;
        else if (v > 18'sd255) return 8'd255;
        else                   return v[7:0];
    endfunction

    logic        fvalReg, lowSeen;
    logic        accept, frameRise;
    logic [10:0] xCnt, yCnt, curX, curY;
    logic [7:0]  r, g, b;

    assign accept    = pix.dval & pix.fval;
    assign frameRise = pix.fval & ~fvalReg;
    assign curX      = frameRise ? 11'd0 : xCnt;
    assign curY      = frameRise ? 11'd0 : yCnt;
    assign r         = pix.red[11:4];
    assign g         = pix.green[11:4];
    assign b         = pix.blue[11:4];

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            fvalReg <= 1'b0;
            lowSeen <= 1'b0;
            xCnt    <= '0;
            yCnt    <= '0;
        end else begin
            fvalReg <= pix.fval;
            lowSeen <= lowSeen | ~pix.fval;
            if (accept) begin
                if (curX == XLast) begin
                    xCnt <= '0;
                    yCnt <= (curY == YLast) ? 11'd0 : curY + 11'd1;
                end else begin
                    xCnt <= curX + 11'd1;
                    yCnt <= curY;
                end
            end else if (frameRise) begin
                xCnt <= '0;
                yCnt <= '0;
            end
        end
    end

    logic               v1, v2;
    logic [10:0]        x1, y1, x2, y2;
    logic signed [17:0] pCbR, pCbG, pCbB, pCrR, pCrG, pCrB;
    logic signed [17:0] cbS, crS, cbT, crT;
    logic [7:0]         cb, cr;
    logic               skinC;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            v1 <= 1'b0; x1 <= '0; y1 <= '0;
            pCbR <= '0; pCbG <= '0; pCbB <= '0;
            pCrR <= '0; pCrG <= '0; pCrB <= '0;
            v2 <= 1'b0; x2 <= '0; y2 <= '0;
            cbS <= '0; crS <= '0;
            oDVAL <= 1'b0; oSKIN <= 1'b0;
            oX <= '0; oY <= '0;
        end else begin
            v1   <= accept;
            x1   <= curX;
            y1   <= curY;
            pCbR <= mul(-18'sd38, r);
            pCbG <= mul(-18'sd74, g);
            pCbB <= mul(18'sd112, b);
            pCrR <= mul(18'sd112, r);
            pCrG <= mul(-18'sd94, g);
            pCrB <= mul(-18'sd18, b);
            v2   <= v1;
            x2   <= x1;
            y2   <= y1;
            cbS  <= pCbR + pCbG + pCbB + 18'sd128;
            crS  <= pCrR + pCrG + pCrB + 18'sd128;
            oDVAL <= v2;
            oSKIN <= v2 & skinC;
            oX    <= x2;
            oY    <= y2;
        end
    end

    // Flooring shift keeps negative chroma sums rounding toward -inf.
    assign cbT   = (cbS >>> 8) + 18'sd128;
    assign crT   = (crS >>> 8) + 18'sd128;
    assign cb    = clamp8(cbT);
    assign cr    = clamp8(crT);
    assign skinC = (cb >= CbLo) && (cb <= CbHi) &&
                   (cr >= CrLo) && (cr <= CrHi);

    // Frame flags track the pipeline; lowSeen drops a frame cut by reset.
    logic        fD1, fD2, fD3, fD4;
    logic        rise3, fall3, hit;
    logic [10:0] wXmin, wXmax, wYmin, wYmax;
    logic [10:0] bXmin, bXmax, bYmin, bYmax;
    logic [10:0] nXmin, nXmax, nYmin, nYmax;
    logic [19:0] wCnt, bCnt, nCnt;

    assign rise3 = fD3 & ~fD4;
    assign fall3 = ~fD3 & fD4;
    assign hit   = oDVAL & oSKIN;

    always_comb begin
        bXmin = rise3 ? MinInit : wXmin;
        bYmin = rise3 ? MinInit : wYmin;
        bXmax = rise3 ? 11'd0 : wXmax;
        bYmax = rise3 ? 11'd0 : wYmax;
        bCnt  = rise3 ? 20'd0 : wCnt;
        nXmin = (hit && oX < bXmin) ? oX : bXmin;
        nXmax = (hit && oX > bXmax) ? oX : bXmax;
        nYmin = (hit && oY < bYmin) ? oY : bYmin;
        nYmax = (hit && oY > bYmax) ? oY : bYmax;
        nCnt  = (hit && bCnt != CntMax) ? bCnt + 20'd1 : bCnt;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            fD1 <= 1'b0; fD2 <= 1'b0; fD3 <= 1'b0; fD4 <= 1'b0;
            wXmin <= MinInit; wYmin <= MinInit;
            wXmax <= '0; wYmax <= '0; wCnt <= '0;
            oBOX_XMIN <= '0; oBOX_XMAX <= '0;
            oBOX_YMIN <= '0; oBOX_YMAX <= '0;
            oSKIN_CNT <= '0; oBOX_FOUND <= 1'b0;
            oBOX_VALID <= 1'b0;
        end else begin
            fD1 <= pix.fval & lowSeen;
            fD2 <= fD1;
            fD3 <= fD2;
            fD4 <= fD3;
            wXmin <= nXmin; wXmax <= nXmax;
            wYmin <= nYmin; wYmax <= nYmax;
            wCnt  <= nCnt;
            oBOX_VALID <= fall3;
            if (fall3) begin
                oBOX_XMIN  <= nXmin;
                oBOX_XMAX  <= nXmax;
                oBOX_YMIN  <= nYmin;
                oBOX_YMAX  <= nYmax;
                oSKIN_CNT  <= nCnt;
                oBOX_FOUND <= (nCnt != 20'd0);
            end
        end
    end
endmodule
